// File: rtl/spi_slave.sv
// SPI responder (CPOL=0, LSB first) running on the system clock.
// SCLK/CS/MOSI are oversampled through synchronizers; one-entry TX buffer.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  input  logic                  txLoad,
  output logic                  txReady,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  rxValid,
  output logic                  txUnderrun,
  output logic                  frameError,
  output logic                  busy,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  misoOe
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int SW = $clog2(SYNC_STAGES + 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [SYNC_STAGES-1:0] sclkSync, csSync, mosiSync;
  logic                   sclkDly, csDly;
  logic [SW-1:0]          settleCnt;
  logic [1:0]             state;
  logic [CW-1:0]          bitCnt;
  logic                   txFull;
  logic [DATA_WIDTH-1:0]  txBuf, txShift, rxShift, rxNext;

  logic sclkS, csS, mosiS, settled;
  logic sclkRise, sclkFall, csFall, csRise;
  logic frameStart, loadAcc, shiftRise, shiftFall;

  assign sclkS = sclkSync[SYNC_STAGES-1];
  assign csS   = csSync[SYNC_STAGES-1];
  assign mosiS = mosiSync[SYNC_STAGES-1];

  // Edges are ignored until the synchronizers hold real post-reset samples,
  // so a CS already low when reset releases never looks like a frame start.
  assign settled  = (settleCnt == SW'(SYNC_STAGES + 1));
  assign sclkRise = settled &  sclkS & ~sclkDly;
  assign sclkFall = settled & ~sclkS &  sclkDly;
  assign csFall   = settled & ~csS   &  csDly;
  assign csRise   = settled &  csS   & ~csDly;

  assign frameStart = (state == IDLE) && csFall;
  // A load coinciding with frame start lands in the buffer freed by that start.
  assign loadAcc    = txLoad && (!txFull || frameStart);
  assign shiftRise  = (state == SHIFT) && !csRise && sclkRise;
  assign shiftFall  = (state == SHIFT) && !csRise && sclkFall;
  assign rxNext     = {mosiS, rxShift[DATA_WIDTH-1:1]};

  assign txReady = ~txFull;
  assign busy    = (state != IDLE);
  assign misoOe  = ~csS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclkSync          <= '0;
      csSync            <= '1;
      mosiSync          <= '0;
      sclkDly           <= 1'b0;
      csDly             <= 1'b1;
      settleCnt         <= '0;
      state             <= IDLE;
      bitCnt            <= '0;
      txFull            <= 1'b0;
      slaveDataReceived <= '0;
      rxValid           <= 1'b0;
      txUnderrun        <= 1'b0;
      frameError        <= 1'b0;
      MISO              <= 1'b0;
    end else begin
      sclkSync   <= {sclkSync[SYNC_STAGES-2:0], SCLK};
      csSync     <= {csSync[SYNC_STAGES-2:0], CS};
      mosiSync   <= {mosiSync[SYNC_STAGES-2:0], MOSI};
      sclkDly    <= sclkS;
      csDly      <= csS;
      rxValid    <= 1'b0;
      txUnderrun <= 1'b0;
      frameError <= 1'b0;
      if (!settled) settleCnt <= settleCnt + SW'(1);

      if (loadAcc)         txFull <= 1'b1;
      else if (frameStart) txFull <= 1'b0;

      case (state)
        IDLE: begin
          MISO <= 1'b0;
          if (csFall) begin
            state      <= SHIFT;
            bitCnt     <= '0;
            txUnderrun <= ~txFull;
          end
        end
        SHIFT: begin
          if (csRise) begin
            frameError <= 1'b1;
            MISO       <= 1'b0;
            state      <= IDLE;
          end else if (sclkRise) begin
            MISO <= txShift[0];
          end else if (sclkFall) begin
            bitCnt <= bitCnt + CW'(1);
            if (bitCnt == CW'(DATA_WIDTH - 1)) begin
              state             <= DONE;
              slaveDataReceived <= rxNext;
              rxValid           <= 1'b1;
            end
          end
        end
        DONE: begin
          if (csRise) begin
            MISO  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (loadAcc) txBuf <= slaveDataToSend;
    if (frameStart)     txShift <= txFull ? txBuf : '0;
    else if (shiftRise) txShift <= txShift >> 1;
    if (shiftFall) rxShift <= rxNext;
  end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master plus a scoreboard of received bytes.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] slaveDataToSend = '0;
  logic       txLoad = 1'b0;
  logic       txReady;
  logic [7:0] slaveDataReceived;
  logic       rxValid, txUnderrun, frameError, busy;
  logic       SCLK = 1'b0;
  logic       CS = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO, misoOe;

  int errCnt = 0;
  int chkCnt = 0;
  int rxCnt = 0;
  int urCnt = 0;
  int feCnt = 0;
  bit monOn = 1'b0;
  logic [7:0] rxQ[$];

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .slaveDataToSend(slaveDataToSend), .txLoad(txLoad), .txReady(txReady),
    .slaveDataReceived(slaveDataReceived), .rxValid(rxValid),
    .txUnderrun(txUnderrun), .frameError(frameError), .busy(busy),
    .SCLK(SCLK), .CS(CS), .MOSI(MOSI), .MISO(MISO), .misoOe(misoOe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chkCnt++;
    if (act !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every rxValid pops the byte expected for that frame.
  always @(negedge clk) begin
    if (monOn) begin
      if (rxValid) begin
        rxCnt++;
        if (rxQ.size() == 0) chk("rxUnexpected", 32'd1, 32'd0);
        else chk("rxData", {24'd0, slaveDataReceived}, {24'd0, rxQ.pop_front()});
      end
      if (txUnderrun) urCnt++;
      if (frameError) feCnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic loadByte(input logic [7:0] d);
    @(negedge clk);
    slaveDataToSend = d;
    txLoad = 1'b1;
    @(negedge clk);
    txLoad = 1'b0;
  endtask

  // SCLK = clk/8; MOSI and SCLK rise together, master samples MISO at the fall.
  task automatic sclkBits(input logic [7:0] mosiByte, input int nBits, output logic [7:0] misoByte);
    misoByte = '0;
    for (int i = 0; i < nBits; i++) begin
      SCLK = 1'b1;
      MOSI = mosiByte[i];
      repeat (4) @(negedge clk);
      misoByte[i] = MISO;
      SCLK = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic xfer(input logic [7:0] mosiByte, input int nBits, output logic [7:0] misoByte);
    @(negedge clk);
    CS = 1'b0;
    repeat (4) @(negedge clk);
    sclkBits(mosiByte, nBits, misoByte);
    CS = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0] got;
  int rx0, ur0, fe0;

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rstTxReady", txReady, 1);
    chk("rstBusy", busy, 0);
    chk("rstMiso", {MISO, misoOe}, 0);
    chk("rstPulses", {rxValid, txUnderrun, frameError}, 0);
    chk("rstRxData", slaveDataReceived, 0);
    @(negedge clk);
    reset = 1'b1;
    monOn = 1'b1;
    repeat (6) @(negedge clk);

    // basic exchange
    loadByte(8'b00001001);
    chk("basicTxReadyLow", txReady, 0);
    rx0 = rxCnt; ur0 = urCnt;
    rxQ.push_back(8'h53);
    xfer(8'b01010011, 8, got);
    chk("basicMiso", got, 8'h09);
    chk("basicRxPulses", rxCnt - rx0, 1);
    chk("basicNoUnderrun", urCnt - ur0, 0);
    chk("basicTxReady", txReady, 1);
    chk("basicIdle", {busy, misoOe, MISO}, 0);

    // back-to-back, second byte loaded mid-frame
    loadByte(8'h98);
    rx0 = rxCnt;
    rxQ.push_back(8'h3C);
    fork
      xfer(8'h3C, 8, got);
      begin
        repeat (20) @(negedge clk);
        loadByte(8'hFF);
      end
    join
    chk("b2bMiso1", got, 8'h98);
    chk("b2bTxReadyFull", txReady, 0);
    rxQ.push_back(8'h55);
    xfer(8'h55, 8, got);
    chk("b2bMiso2", got, 8'hFF);
    chk("b2bRxPulses", rxCnt - rx0, 2);

    // underrun
    rx0 = rxCnt; ur0 = urCnt;
    rxQ.push_back(8'h5F);
    xfer(8'h5F, 8, got);
    chk("urMiso", got, 8'h00);
    chk("urPulses", urCnt - ur0, 1);
    chk("urRxPulses", rxCnt - rx0, 1);

    // abort after 4 bits
    rx0 = rxCnt; fe0 = feCnt;
    xfer(8'hE7, 4, got);
    chk("abortFrameErr", feCnt - fe0, 1);
    chk("abortNoRx", rxCnt - rx0, 0);
    chk("abortRxHeld", slaveDataReceived, 8'h5F);
    rxQ.push_back(8'hA5);
    xfer(8'hA5, 8, got);
    chk("postAbortRx", rxCnt - rx0, 1);

    // reset mid-frame
    loadByte(8'h77);
    rx0 = rxCnt;
    @(negedge clk);
    CS = 1'b0;
    repeat (4) @(negedge clk);
    sclkBits(8'h0F, 3, got);
    reset = 1'b0;
    #1;
    chk("midRstBusy", busy, 0);
    chk("midRstTxReady", txReady, 1);
    chk("midRstMiso", {MISO, misoOe}, 0);
    chk("midRstRxData", slaveDataReceived, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sclkBits(8'h1F, 5, got);
    chk("midRstIgnored", {rxCnt - rx0, 31'(busy)}, 0);
    CS = 1'b1;
    repeat (8) @(negedge clk);
    rxQ.push_back(8'hC3);
    xfer(8'hC3, 8, got);
    chk("postRstMiso", got, 8'h00);
    chk("postRstRx", rxCnt - rx0, 1);

    // load rejection
    loadByte(8'h11);
    loadByte(8'h22);
    chk("rejTxReady", txReady, 0);
    rxQ.push_back(8'h7E);
    xfer(8'h7E, 8, got);
    chk("rejMiso", got, 8'h11);

    repeat (4) @(negedge clk);
    chk("sbDrained", rxQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
